// File: rtl/osd_mixer_pkg.sv
// osd_mixer_pkg: blend mode encoding and the reset-time palette contents
// shared by the OSD mixer top level and its per-channel blend unit.
package osd_mixer_pkg;

    // Widest colour channel the default-palette helper can build.
    localparam int MAX_COLOR_W = 32;

    typedef enum logic [1:0] {
        MODE_OPAQUE  = 2'd0,
        MODE_HALF    = 2'd1,
        MODE_QUARTER = 2'd2,
        MODE_BYPASS  = 2'd3
    } mode_e;

    // Reset palette entry {R,G,B} at channel width cw: 0 black, 1 blue,
    // 2 yellow, everything above white. The result is right-aligned; the
    // caller truncates it to 3*cw bits.
    function automatic logic [3*MAX_COLOR_W-1:0] pal_default(input int unsigned idx,
                                                             input int unsigned cw);
        logic [3*MAX_COLOR_W-1:0] full;
        logic [3*MAX_COLOR_W-1:0] r;
        logic [3*MAX_COLOR_W-1:0] g;
        logic [3*MAX_COLOR_W-1:0] b;
        full = {(3*MAX_COLOR_W){1'b1}} >> (3*MAX_COLOR_W - cw);
        r = '0;
        g = '0;
        b = '0;
        case (idx)
            0: ;
            1: b = full;
            2: begin
                r = full;
                g = full;
            end
            default: begin
                r = full;
                g = full;
                b = full;
            end
        endcase
        return (r << (2*cw)) | (g << cw) | b;
    endfunction

endpackage

// File: rtl/osd_mixer_if.sv
// osd_mixer_if: video-in, OSD, palette-write and mixed-video-out bundle.
// The source side (master) drives the *_i signals, the mixer (slave)
// drives the *_o signals.
interface osd_mixer_if #(
    parameter int COLOR_W     = 8,
    parameter int OSD_COLOR_W = 2
);
    logic [COLOR_W-1:0]     R_i, G_i, B_i;
    logic                   HSYNC_i, VSYNC_i, DE_i;
    logic                   osd_enable_i;
    logic [OSD_COLOR_W-1:0] osd_color_i;
    logic [1:0]             mode_i;
    logic                   pal_we_i;
    logic [OSD_COLOR_W-1:0] pal_addr_i;
    logic [3*COLOR_W-1:0]   pal_wdata_i;
    logic [COLOR_W-1:0]     R_o, G_o, B_o;
    logic                   HSYNC_o, VSYNC_o, DE_o;
    logic                   frame_commit_o;

    modport master (
        output R_i, G_i, B_i, HSYNC_i, VSYNC_i, DE_i,
        output osd_enable_i, osd_color_i, mode_i,
        output pal_we_i, pal_addr_i, pal_wdata_i,
        input  R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, frame_commit_o
    );

    modport slave (
        input  R_i, G_i, B_i, HSYNC_i, VSYNC_i, DE_i,
        input  osd_enable_i, osd_color_i, mode_i,
        input  pal_we_i, pal_addr_i, pal_wdata_i,
        output R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, frame_commit_o
    );
endinterface

// File: rtl/osd_blend.sv
// osd_blend: combinational mix of one colour channel (palette vs video).
// Half/quarter blending exists only when OSD_MIXER_BLEND_EN is defined;
// otherwise those modes fall back to opaque and no adders are built.
module osd_blend
    import osd_mixer_pkg::*;
#(
    parameter int COLOR_W = 8
) (
    input  logic [COLOR_W-1:0] pal_i,
    input  logic [COLOR_W-1:0] vid_i,
    input  logic               osd_en_i,
    input  mode_e              mode_i,
    input  logic               de_i,
    output logic [COLOR_W-1:0] pix_o
);

`ifdef OSD_MIXER_BLEND_EN
    // (pal + vid) >> 1 with one guard bit, so the sum never wraps.
    function automatic logic [COLOR_W-1:0] blend_half(input logic [COLOR_W-1:0] p,
                                                      input logic [COLOR_W-1:0] v);
        logic [COLOR_W:0] s;
        s = {1'b0, p} + {1'b0, v};
        return s[COLOR_W:1];
    endfunction

    // (pal + 3*vid) >> 2 with two guard bits; 4*max fits exactly.
    function automatic logic [COLOR_W-1:0] blend_quarter(input logic [COLOR_W-1:0] p,
                                                         input logic [COLOR_W-1:0] v);
        logic [COLOR_W+1:0] s;
        s = {2'b00, p} + {2'b00, v} + {1'b0, v, 1'b0};
        return s[COLOR_W+1:2];
    endfunction
`endif

    // Select the channel value; blanking overrides every mode.
    always_comb begin
        pix_o = vid_i;
        if (!de_i) begin
            pix_o = '0;
        end else if (osd_en_i) begin
            case (mode_i)
                MODE_OPAQUE:  pix_o = pal_i;
`ifdef OSD_MIXER_BLEND_EN
                MODE_HALF:    pix_o = blend_half(pal_i, vid_i);
                MODE_QUARTER: pix_o = blend_quarter(pal_i, vid_i);
`else
                MODE_HALF:    pix_o = pal_i;
                MODE_QUARTER: pix_o = pal_i;
`endif
                MODE_BYPASS:  pix_o = vid_i;
                default:      pix_o = vid_i;
            endcase
        end
    end

endmodule

// File: rtl/osd_mixer.sv
// osd_mixer: two-stage OSD overlay on a parallel RGB video stream.
// Stage 1 registers the video/timing and looks up the active palette;
// stage 2 blends and registers the outputs. Palette and mode writes go to
// shadow copies that are committed on the VSYNC active edge.
// Optional blend modes: define OSD_MIXER_BLEND_EN.
module osd_mixer
    import osd_mixer_pkg::*;
#(
    parameter int COLOR_W     = 8,
    parameter int OSD_COLOR_W = 2,
    parameter int VS_POL      = 0
) (
    input logic        PCLK_i,
    input logic        reset_n,
    osd_mixer_if.slave bus
);

    localparam int   NPAL   = 1 << OSD_COLOR_W;
    localparam int   PAL_W  = 3 * COLOR_W;
    localparam logic VS_ACT = (VS_POL != 0);

    logic [PAL_W-1:0] shd_bank_q [NPAL];
    logic [PAL_W-1:0] act_bank_q [NPAL];
    mode_e            shd_mode_q, act_mode_q;

    logic [COLOR_W-1:0] r_p1_q, g_p1_q, b_p1_q;
    logic [PAL_W-1:0]   pal_p1_q;
    logic               osd_en_p1_q, hs_p1_q, vs_p1_q, de_p1_q, vld_p1_q;
    mode_e              mode_p1_q;

    logic [COLOR_W-1:0] r_p2_q, g_p2_q, b_p2_q;
    logic [COLOR_W-1:0] r_p2_d, g_p2_d, b_p2_d;
    logic               hs_p2_q, vs_p2_q, de_p2_q, vld_p2_q, commit_p2_q;
    logic               commit_d;

    // VSYNC entering its active level, seen on two genuine post-reset samples.
    always_comb begin
        commit_d = vld_p2_q && (vs_p1_q == VS_ACT) && (vs_p2_q != VS_ACT);
    end

    // Palette banks: shadow takes CPU writes, active takes shadow at commit.
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            for (int i = 0; i < NPAL; i++) begin
                shd_bank_q[i] <= PAL_W'(pal_default(i, COLOR_W));
                act_bank_q[i] <= PAL_W'(pal_default(i, COLOR_W));
            end
        end else begin
            if (commit_d) begin
                for (int i = 0; i < NPAL; i++) begin
                    act_bank_q[i] <= shd_bank_q[i];
                end
            end
            if (bus.pal_we_i) begin
                shd_bank_q[bus.pal_addr_i] <= bus.pal_wdata_i;
            end
        end
    end

    // Mode registers: shadow follows mode_i, active updates at commit.
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            shd_mode_q <= MODE_OPAQUE;
            act_mode_q <= MODE_OPAQUE;
        end else begin
            shd_mode_q <= mode_e'(bus.mode_i);
            if (commit_d) begin
                act_mode_q <= shd_mode_q;
            end
        end
    end

    // ---- stage 1: register inputs, palette lookup, capture active mode ----
    // Mode travels with the pixel so palette and mode always match.
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            r_p1_q      <= '0;
            g_p1_q      <= '0;
            b_p1_q      <= '0;
            pal_p1_q    <= '0;
            osd_en_p1_q <= 1'b0;
            mode_p1_q   <= MODE_OPAQUE;
            hs_p1_q     <= 1'b0;
            vs_p1_q     <= 1'b0;
            de_p1_q     <= 1'b0;
            vld_p1_q    <= 1'b0;
        end else begin
            r_p1_q      <= bus.R_i;
            g_p1_q      <= bus.G_i;
            b_p1_q      <= bus.B_i;
            pal_p1_q    <= act_bank_q[bus.osd_color_i];
            osd_en_p1_q <= bus.osd_enable_i;
            mode_p1_q   <= act_mode_q;
            hs_p1_q     <= bus.HSYNC_i;
            vs_p1_q     <= bus.VSYNC_i;
            de_p1_q     <= bus.DE_i;
            vld_p1_q    <= 1'b1;
        end
    end

    // ---- stage 2: per-channel blend ----
    osd_blend #(.COLOR_W(COLOR_W)) u_blend_r (
        .pal_i(pal_p1_q[3*COLOR_W-1:2*COLOR_W]), .vid_i(r_p1_q),
        .osd_en_i(osd_en_p1_q), .mode_i(mode_p1_q), .de_i(de_p1_q), .pix_o(r_p2_d)
    );
    osd_blend #(.COLOR_W(COLOR_W)) u_blend_g (
        .pal_i(pal_p1_q[2*COLOR_W-1:COLOR_W]), .vid_i(g_p1_q),
        .osd_en_i(osd_en_p1_q), .mode_i(mode_p1_q), .de_i(de_p1_q), .pix_o(g_p2_d)
    );
    osd_blend #(.COLOR_W(COLOR_W)) u_blend_b (
        .pal_i(pal_p1_q[COLOR_W-1:0]), .vid_i(b_p1_q),
        .osd_en_i(osd_en_p1_q), .mode_i(mode_p1_q), .de_i(de_p1_q), .pix_o(b_p2_d)
    );

    // Output register; the commit pulse lands with the first active VSYNC_o.
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            r_p2_q      <= '0;
            g_p2_q      <= '0;
            b_p2_q      <= '0;
            hs_p2_q     <= 1'b0;
            vs_p2_q     <= 1'b0;
            de_p2_q     <= 1'b0;
            vld_p2_q    <= 1'b0;
            commit_p2_q <= 1'b0;
        end else begin
            r_p2_q      <= r_p2_d;
            g_p2_q      <= g_p2_d;
            b_p2_q      <= b_p2_d;
            hs_p2_q     <= hs_p1_q;
            vs_p2_q     <= vs_p1_q;
            de_p2_q     <= de_p1_q;
            vld_p2_q    <= vld_p1_q;
            commit_p2_q <= commit_d;
        end
    end

    assign bus.R_o            = r_p2_q;
    assign bus.G_o            = g_p2_q;
    assign bus.B_o            = b_p2_q;
    assign bus.HSYNC_o        = hs_p2_q;
    assign bus.VSYNC_o        = vs_p2_q;
    assign bus.DE_o           = de_p2_q;
    assign bus.frame_commit_o = commit_p2_q;

endmodule
